// File: rtl/mem_stage_lsu.sv
// Memory stage of the RV32I pipeline: byte/half/word data memory with load extension,
// misalignment faults and optional wait states that stall the upstream stages.
module mem_stage_lsu #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic        MemReadM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  funct3M,
    input  logic [4:0]  RD_M,
    input  logic [31:0] PCPlus4M,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] ALU_ResultM,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [4:0]  RD_W,
    output logic [31:0] PCPlus4W,
    output logic [31:0] ALU_ResultW,
    output logic [31:0] ReadDataW,
    output logic        FaultW,
    output logic        StallM,
    output logic        dbg_state
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] mem [DEPTH];

    logic        access, size_bad, misalign, fault, valid_acc, stall, mem_we;
    logic [AW-1:0] word_idx;
    logic [3:0]  be;
    logic [31:0] wr_lanes, rd_word, rd_shift, load_data;

    logic        reg_write_d, fault_d;
    logic [1:0]  result_src_d;
    logic [4:0]  rd_d;
    logic [31:0] pc_plus4_d, alu_result_d, read_data_d;
    logic        reg_write_q, fault_q;
    logic [1:0]  result_src_q;
    logic [4:0]  rd_q;
    logic [31:0] pc_plus4_q, alu_result_q, read_data_q;

    always_comb begin
        access    = MemReadM | MemWriteM;
        size_bad  = (funct3M == 3'b011) || (funct3M[2:1] == 2'b11);
        misalign  = ((funct3M[1:0] == 2'b01) && ALU_ResultM[0]) ||
                    ((funct3M[1:0] == 2'b10) && (ALU_ResultM[1:0] != 2'b00));
        fault     = access && (size_bad || misalign);
        valid_acc = access && !fault;
        word_idx  = ALU_ResultM[AW+1:2];
    end

    // Wait-state sequencer: the access completes on the edge where StallM is low.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        if (WAIT_STATES > 0) begin
            case (state_q)
                S_IDLE: begin
                    if (valid_acc) begin
                        stall   = 1'b1;
                        cnt_d   = 4'(WAIT_STATES - 1);
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        stall = 1'b1;
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign StallM    = stall && rst;
    assign dbg_state = (state_q == S_WAIT);

    // Store lanes: replicate the narrow datum across the word and enable only the target lanes.
    always_comb begin
        be       = 4'b0000;
        wr_lanes = WriteDataM;
        case (funct3M[1:0])
            2'b00: begin
                be       = 4'b0001 << ALU_ResultM[1:0];
                wr_lanes = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                be       = ALU_ResultM[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{WriteDataM[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        mem_we = valid_acc && MemWriteM && !stall && rst;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
            end
        end
    end

    always_comb begin
        rd_word  = mem[word_idx];
        rd_shift = rd_word >> {ALU_ResultM[1:0], 3'b000};
        case (funct3M)
            3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b010:  load_data = rd_shift;
            3'b100:  load_data = {24'd0, rd_shift[7:0]};
            3'b101:  load_data = {16'd0, rd_shift[15:0]};
            default: load_data = 32'd0;
        endcase
    end

    // A stalled cycle hands a bubble to writeback; otherwise the instruction is captured.
    always_comb begin
        reg_write_d  = 1'b0;
        fault_d      = 1'b0;
        result_src_d = 2'b00;
        rd_d         = 5'd0;
        pc_plus4_d   = 32'd0;
        alu_result_d = 32'd0;
        read_data_d  = 32'd0;
        if (!stall) begin
            reg_write_d  = RegWriteM && !fault;
            fault_d      = fault;
            result_src_d = ResultSrcM;
            rd_d         = RD_M;
            pc_plus4_d   = PCPlus4M;
            alu_result_d = ALU_ResultM;
            if (valid_acc && MemReadM && !MemWriteM) read_data_d = load_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            reg_write_q  <= 1'b0;
            fault_q      <= 1'b0;
            result_src_q <= 2'b00;
            rd_q         <= 5'd0;
            pc_plus4_q   <= 32'd0;
            alu_result_q <= 32'd0;
            read_data_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            reg_write_q  <= reg_write_d;
            fault_q      <= fault_d;
            result_src_q <= result_src_d;
            rd_q         <= rd_d;
            pc_plus4_q   <= pc_plus4_d;
            alu_result_q <= alu_result_d;
            read_data_q  <= read_data_d;
        end
    end

    assign RegWriteW   = reg_write_q;
    assign FaultW      = fault_q;
    assign ResultSrcW  = result_src_q;
    assign RD_W        = rd_q;
    assign PCPlus4W    = pc_plus4_q;
    assign ALU_ResultW = alu_result_q;
    assign ReadDataW   = read_data_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: one instance with no wait states (d=0) and one with three (d=1),
// each checked against a scoreboard fed by a small reference memory model.
module tb_mem_stage_lsu;
  localparam int OW = 105;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [2];
  logic        i_rw [2], i_mw [2], i_mr [2];
  logic [1:0]  i_rs [2];
  logic [2:0]  i_f3 [2];
  logic [4:0]  i_rd [2];
  logic [31:0] i_pc [2], i_wd [2], i_addr [2];
  logic        o_rw [2], o_fault [2], o_stall [2], o_dbg [2];
  logic [1:0]  o_rs [2];
  logic [4:0]  o_rd [2];
  logic [31:0] o_pc [2], o_alu [2], o_rdata [2];

  mem_stage_lsu #(.DEPTH(1024), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst_n[0]), .RegWriteM(i_rw[0]), .MemWriteM(i_mw[0]), .MemReadM(i_mr[0]),
    .ResultSrcM(i_rs[0]), .funct3M(i_f3[0]), .RD_M(i_rd[0]), .PCPlus4M(i_pc[0]),
    .WriteDataM(i_wd[0]), .ALU_ResultM(i_addr[0]), .RegWriteW(o_rw[0]), .ResultSrcW(o_rs[0]),
    .RD_W(o_rd[0]), .PCPlus4W(o_pc[0]), .ALU_ResultW(o_alu[0]), .ReadDataW(o_rdata[0]),
    .FaultW(o_fault[0]), .StallM(o_stall[0]), .dbg_state(o_dbg[0])
  );

  mem_stage_lsu #(.DEPTH(1024), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst_n[1]), .RegWriteM(i_rw[1]), .MemWriteM(i_mw[1]), .MemReadM(i_mr[1]),
    .ResultSrcM(i_rs[1]), .funct3M(i_f3[1]), .RD_M(i_rd[1]), .PCPlus4M(i_pc[1]),
    .WriteDataM(i_wd[1]), .ALU_ResultM(i_addr[1]), .RegWriteW(o_rw[1]), .ResultSrcW(o_rs[1]),
    .RD_W(o_rd[1]), .PCPlus4W(o_pc[1]), .ALU_ResultW(o_alu[1]), .ReadDataW(o_rdata[1]),
    .FaultW(o_fault[1]), .StallM(o_stall[1]), .dbg_state(o_dbg[1])
  );

  int n_checks = 0;
  int n_fail = 0;
  logic [OW-1:0] exp_q0[$];
  logic [OW-1:0] exp_q1[$];
  logic [31:0] mm [2][1024];

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] out_vec(input int d);
    return {o_rw[d], o_rs[d], o_rd[d], o_fault[d], o_rdata[d], o_alu[d], o_pc[d]};
  endfunction

  // Reference model of one access: updates the model memory and returns the expected W fields.
  task automatic model(input int d, input logic regw, we, re, input logic [1:0] rs,
                       input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] pc, wd, addr,
                       output logic [OW-1:0] e, output logic v);
    logic acc, flt;
    logic [9:0] w;
    logic [31:0] sh, ld;
    acc = we | re;
    flt = acc && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111 ||
                  (f3[1:0] == 2'b01 && addr[0]) ||
                  (f3[1:0] == 2'b10 && addr[1:0] != 2'b00));
    w  = addr[11:2];
    ld = 32'd0;
    if (acc && !flt) begin
      if (we) begin
        case (f3[1:0])
          2'b00:   mm[d][w][8*addr[1:0] +: 8] = wd[7:0];
          2'b01:   mm[d][w][16*addr[1] +: 16] = wd[15:0];
          default: mm[d][w] = wd;
        endcase
      end else begin
        sh = mm[d][w] >> (8*addr[1:0]);
        case (f3)
          3'b000:  ld = {{24{sh[7]}}, sh[7:0]};
          3'b001:  ld = {{16{sh[15]}}, sh[15:0]};
          3'b100:  ld = {24'd0, sh[7:0]};
          3'b101:  ld = {16'd0, sh[15:0]};
          default: ld = sh;
        endcase
      end
    end
    v = acc && !flt;
    e = {regw && !flt, rs, rd, flt, ld, addr, pc};
  endtask

  task automatic set_in(input int d, input logic we, re, input logic [2:0] f3,
                        input logic [31:0] addr, wd);
    i_mw[d]   = we;
    i_mr[d]   = re;
    i_rw[d]   = re && !we;
    i_rs[d]   = (re && !we) ? 2'b01 : 2'b00;
    i_f3[d]   = f3;
    i_addr[d] = addr;
    i_wd[d]   = wd;
    i_rd[d]   = 5'($urandom_range(1, 31));
    i_pc[d]   = $urandom;
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that captured the instruction.
  task automatic issue(input int d, input logic we, re, input logic [2:0] f3,
                       input logic [31:0] addr, wd);
    logic [OW-1:0] e, got;
    logic v;
    int stalls, want_stalls;
    set_in(d, we, re, f3, addr, wd);
    model(d, i_rw[d], we, re, i_rs[d], f3, i_rd[d], i_pc[d], wd, addr, e, v);
    if (d == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
    want_stalls = (d == 1 && v) ? 3 : 0;
    #1;
    stalls = 0;
    for (int c = 0; c < 20; c++) begin
      if (!o_stall[d]) break;
      stalls++;
      @(posedge clk); #1;
      check_val("bubble", out_vec(d), '0);
    end
    @(posedge clk); #1;
    got = out_vec(d);
    if (d == 0) begin
      if (exp_q0.size() == 0) check_val("q0_empty", 1, 0);
      else check_val("w_out0", got, exp_q0.pop_front());
    end else begin
      if (exp_q1.size() == 0) check_val("q1_empty", 1, 0);
      else check_val("w_out3", got, exp_q1.pop_front());
    end
    check_val("stall_cycles", stalls, want_stalls);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 1024; w++) mm[d][w] = 32'd0;
      rst_n[d] = 1'b0;
      set_in(d, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    end
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_out0", out_vec(0), '0);
    check_val("reset_out3", out_vec(1), '0);
    check_val("reset_stall3", o_stall[1], 0);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // No wait states: directed sequence from the access-size cases.
    issue(0, 0, 0, 3'b000, 32'h0000_0044, 32'h0);
    issue(0, 1, 0, 3'b010, 32'h10, 32'hDEAD_BEEF);
    issue(0, 0, 1, 3'b010, 32'h10, 32'h0);
    check_val("lw_const", o_rdata[0], 32'hDEAD_BEEF);
    issue(0, 1, 0, 3'b000, 32'h13, 32'h1234_5680);
    issue(0, 0, 1, 3'b000, 32'h13, 32'h0);
    check_val("lb_const", o_rdata[0], 32'hFFFF_FF80);
    issue(0, 0, 1, 3'b100, 32'h13, 32'h0);
    check_val("lbu_const", o_rdata[0], 32'h0000_0080);
    issue(0, 0, 1, 3'b010, 32'h10, 32'h0);
    check_val("lw_after_sb", o_rdata[0], 32'h80AD_BEEF);
    issue(0, 1, 0, 3'b001, 32'h12, 32'hAAAA_8001);
    issue(0, 0, 1, 3'b001, 32'h12, 32'h0);
    check_val("lh_const", o_rdata[0], 32'hFFFF_8001);
    issue(0, 0, 1, 3'b101, 32'h12, 32'h0);
    check_val("lhu_const", o_rdata[0], 32'h0000_8001);
    issue(0, 0, 1, 3'b001, 32'h11, 32'h0);
    check_val("lh_mis_fault", o_fault[0], 1);
    check_val("lh_mis_regw", o_rw[0], 0);
    issue(0, 1, 0, 3'b010, 32'h12, 32'h5555_5555);
    check_val("sw_mis_fault", o_fault[0], 1);
    issue(0, 0, 1, 3'b010, 32'h10, 32'h0);
    check_val("mem_unchanged", o_rdata[0], 32'h8001_BEEF);
    issue(0, 1, 0, 3'b010, 32'h0000_1010, 32'hCAFE_F00D);
    issue(0, 0, 1, 3'b010, 32'h10, 32'h0);
    check_val("alias_word4", o_rdata[0], 32'hCAFE_F00D);
    issue(0, 0, 1, 3'b011, 32'h10, 32'h0);
    check_val("f3_011_fault", o_fault[0], 1);

    for (int w = 0; w < 8; w++) issue(0, 1, 0, 3'b010, 32'(w * 4), 32'h0);
    for (int n = 0; n < 30; n++) begin
      logic [2:0] f3s [6];
      f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};
      issue(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            f3s[$urandom_range(0, 5)], 32'($urandom_range(0, 31)), $urandom);
    end

    // Three wait states.
    issue(1, 0, 0, 3'b000, 32'h0000_0100, 32'h0);
    issue(1, 1, 0, 3'b010, 32'h8, 32'h1234_5678);
    issue(1, 0, 1, 3'b010, 32'h8, 32'h0);
    check_val("ws_lw_const", o_rdata[1], 32'h1234_5678);
    issue(1, 0, 1, 3'b001, 32'h9, 32'h0);
    check_val("ws_fault", o_fault[1], 1);
    issue(1, 0, 1, 3'b100, 32'hB, 32'h0);
    issue(1, 0, 1, 3'b001, 32'hA, 32'h0);
    issue(1, 1, 0, 3'b010, 32'h20, 32'h1111_1111);

    // Reset while a store is waiting: it must never land.
    set_in(1, 1'b1, 1'b0, 3'b010, 32'h20, 32'h2222_2222);
    #1;
    check_val("pre_rst_stall", o_stall[1], 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("pre_rst_wait", o_dbg[1], 1);
    rst_n[1] = 1'b0;
    #1;
    check_val("rst_out", out_vec(1), '0);
    check_val("rst_stall", o_stall[1], 0);
    check_val("rst_state", o_dbg[1], 0);
    set_in(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(posedge clk); #1;
    rst_n[1] = 1'b1;
    issue(1, 0, 1, 3'b010, 32'h20, 32'h0);
    check_val("rst_store_dropped", o_rdata[1], 32'h1111_1111);

    for (int n = 0; n < 10; n++) begin
      issue(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 2)), 32'h20 + 32'($urandom_range(0, 3)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
